// File: rtl/farm_sensor_ctrl.sv
// Farm-road vehicle detector conditioning: synchronise, debounce, count queued
// vehicles, drain them during farm green and raise the farm-road request c.
module farm_sensor_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 4,
    parameter int PASS_CYC     = 3,
    parameter int MIN_QUEUE    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor_raw,
    input  logic             fg,
    output logic             c,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             ovf
);

    localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
    localparam int PW = $clog2(PASS_CYC) + 1;
    localparam logic [DW-1:0]    DCNT_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0]    PTMR_LAST = PW'(PASS_CYC - 1);
    localparam logic [CNT_W-1:0] Q_MAX     = '1;
    localparam logic [CNT_W-1:0] Q_MIN     = CNT_W'(MIN_QUEUE);

    typedef enum logic [1:0] {IDLE, REQ, SERVE} state_t;

    logic             s1_reg, s2_reg;
    logic             db_reg, db_next;
    logic [DW-1:0]    dcnt_reg, dcnt_next;
    logic [PW-1:0]    ptmr_reg, ptmr_next;
    logic [CNT_W-1:0] q_reg, q_next;
    logic             ovf_reg, ovf_next;
    logic             c_reg, c_next;
    state_t           state_reg, state_next;
    logic             arrival, wrap, departure;

    // Debounce: the level only follows s2 after DEBOUNCE_CYC consecutive disagreeing samples.
    always_comb begin
        db_next   = db_reg;
        dcnt_next = '0;
        arrival   = 1'b0;
        if (s2_reg != db_reg) begin
            if (dcnt_reg == DCNT_LAST) begin
                db_next = s2_reg;
                arrival = s2_reg;
            end else begin
                dcnt_next = dcnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        ptmr_next = '0;
        wrap      = 1'b0;
        if (fg) begin
            if (ptmr_reg == PTMR_LAST) begin
                wrap = 1'b1;
            end else begin
                ptmr_next = ptmr_reg + 1'b1;
            end
        end
    end

    assign departure = wrap && (q_reg != '0);

    // Arrival and departure on the same edge cancel; a saturated arrival is dropped and flagged.
    always_comb begin
        q_next   = q_reg;
        ovf_next = ovf_reg;
        if (arrival && !departure) begin
            if (q_reg == Q_MAX) begin
                ovf_next = 1'b1;
            end else begin
                q_next = q_reg + 1'b1;
            end
        end else if (departure && !arrival) begin
            q_next = q_reg - 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (q_next >= Q_MIN) state_next = REQ;
            REQ:     if (fg) state_next = SERVE;
            SERVE:   if (!fg) state_next = (q_next >= Q_MIN) ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
        // Request drops mid-green once the queue is empty so the controller can leave early.
        c_next = (state_next == REQ) || ((state_next == SERVE) && (q_next != '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            db_reg    <= 1'b0;
            dcnt_reg  <= '0;
            ptmr_reg  <= '0;
            q_reg     <= '0;
            ovf_reg   <= 1'b0;
            c_reg     <= 1'b0;
            state_reg <= IDLE;
        end else begin
            s1_reg    <= sensor_raw;
            s2_reg    <= s1_reg;
            db_reg    <= db_next;
            dcnt_reg  <= dcnt_next;
            ptmr_reg  <= ptmr_next;
            q_reg     <= q_next;
            ovf_reg   <= ovf_next;
            c_reg     <= c_next;
            state_reg <= state_next;
        end
    end

    assign c         = c_reg;
    assign queue_cnt = q_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_farm_sensor_ctrl.sv
// Self-checking bench for farm_sensor_ctrl: vector table, directed corner
// sequences and a long randomised run against a behavioural reference model.
module tb_farm_sensor_ctrl;

    localparam int DEB   = 4;
    localparam int CW    = 2;
    localparam int PASS  = 3;
    localparam int MINQ  = 1;
    localparam int QMAX  = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          sensor_raw;
    logic          fg;
    logic          c;
    logic [CW-1:0] queue_cnt;
    logic          ovf;

    farm_sensor_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .CNT_W(CW),
        .PASS_CYC(PASS),
        .MIN_QUEUE(MINQ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sensor_raw(sensor_raw),
        .fg(fg),
        .c(c),
        .queue_cnt(queue_cnt),
        .ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: raw samples reach the debouncer two edges late; the
    // debounced level flips once the last DEB samples all disagree with it.
    bit delay_q[$];
    bit win[$];
    bit m_db;
    int fg_run;
    int m_q;
    bit m_ovf;
    int m_mode;   // 0 idle, 1 requesting, 2 being served
    bit m_c;
    bit model_valid = 1'b0;

    task automatic model_edge(input bit raw, input bit fgv, input bit rstv);
        bit s2_seen, all_diff, arr, dep;
        if (!rstv) begin
            delay_q = '{1'b0, 1'b0};
            win.delete();
            m_db = 0; fg_run = 0; m_q = 0; m_ovf = 0; m_mode = 0; m_c = 0;
            model_valid = 1'b1;
            return;
        end
        if (!model_valid) return;
        s2_seen = delay_q.pop_front();
        delay_q.push_back(raw);
        win.push_back(s2_seen);
        if (win.size() > DEB) void'(win.pop_front());
        all_diff = (win.size() == DEB);
        foreach (win[i]) if (win[i] == m_db) all_diff = 0;
        arr = 0;
        if (all_diff) begin
            m_db = !m_db;
            arr = m_db;
            win.delete();
        end
        fg_run = fgv ? fg_run + 1 : 0;
        dep = fgv && (fg_run % PASS == 0) && (m_q > 0);
        if (arr && !dep) begin
            if (m_q == QMAX) m_ovf = 1;
            else m_q = m_q + 1;
        end else if (dep && !arr) begin
            m_q = m_q - 1;
        end
        case (m_mode)
            0: if (m_q >= MINQ) m_mode = 1;
            1: if (fgv) m_mode = 2;
            default: if (!fgv) m_mode = (m_q >= MINQ) ? 1 : 0;
        endcase
        m_c = (m_mode == 1) || (m_mode == 2 && m_q != 0);
    endtask

    task automatic step(input bit raw, input bit fgv, input bit rstv, input bit glitch);
        @(negedge clk);
        sensor_raw = raw;
        fg         = fgv;
        rst_n      = rstv;
        if (glitch && rstv) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
        end
        @(posedge clk);
        model_edge(raw, fgv, rstv);
        #1;
        if (model_valid) begin
            chk("model_q", int'(queue_cnt), m_q);
            chk("model_c", int'(c), int'(m_c));
            chk("model_ovf", int'(ovf), int'(m_ovf));
        end
    endtask

    task automatic add_vehicle();
        repeat (7) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic raw;
        logic fgv;
        logic rstv;
        int   q;
        logic cc;
        logic ov;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int raw_left, fg_left;
        bit cur_raw, cur_fg;
        sensor_raw = 1'b0;
        fg         = 1'b0;
        rst_n      = 1'b0;

        // Reset, sensor rises before edge 1, then a short green drains the single vehicle.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].raw, vecs[i].fgv, vecs[i].rstv, 1'b0);
            chk($sformatf("vec%0d_q", i), int'(queue_cnt), vecs[i].q);
            chk($sformatf("vec%0d_c", i), int'(c), int'(vecs[i].cc));
            chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].ov));
        end

        // Glitch shorter than the debounce window, then one long pulse.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("glitch_q", int'(queue_cnt), 0);
        chk("glitch_c", int'(c), 0);
        repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pulse_q", int'(queue_cnt), 1);
        chk("pulse_c", int'(c), 1);

        // Three queued vehicles drained by a long green.
        do_reset();
        repeat (3) add_vehicle();
        chk("q3_q", int'(queue_cnt), 3);
        chk("q3_c", int'(c), 1);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (i == 3) chk("drain3_q", int'(queue_cnt), 2);
            if (i == 6) chk("drain6_q", int'(queue_cnt), 1);
            if (i == 8) chk("drain8_c", int'(c), 1);
            if (i == 9) begin
                chk("drain9_q", int'(queue_cnt), 0);
                chk("drain9_c", int'(c), 0);
            end
        end
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("green_empty_c", int'(c), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("green_off_c", int'(c), 0);

        // Arrival and departure land on the same edge, then reset mid-drain.
        do_reset();
        repeat (2) add_vehicle();
        for (int s = 1; s <= 6; s++) begin
            step(1'b1, (s >= 4), 1'b1, 1'b0);
            if (s == 5) chk("pre_both_q", int'(queue_cnt), 2);
        end
        chk("both_q", int'(queue_cnt), 2);
        chk("both_c", int'(c), 1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("async_pulse_q", int'(queue_cnt), 2);
        chk("async_pulse_c", int'(c), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midreset_q", int'(queue_cnt), 0);
        chk("midreset_c", int'(c), 0);
        chk("midreset_ovf", int'(ovf), 0);

        // Saturation with a 2-bit queue; ovf is sticky through the drain.
        do_reset();
        repeat (3) add_vehicle();
        chk("sat3_q", int'(queue_cnt), 3);
        chk("sat3_ovf", int'(ovf), 0);
        add_vehicle();
        chk("sat4_q", int'(queue_cnt), 3);
        chk("sat4_ovf", int'(ovf), 1);
        repeat (9) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat_drain_q", int'(queue_cnt), 0);
        chk("sat_drain_ovf", int'(ovf), 1);
        chk("sat_drain_c", int'(c), 0);

        // Randomised traffic with occasional resets and between-edge rst_n pulses.
        do_reset();
        raw_left = 0;
        fg_left  = 0;
        cur_raw  = 0;
        cur_fg   = 0;
        for (int i = 0; i < 3000; i++) begin
            if (raw_left == 0) begin
                cur_raw  = !cur_raw;
                raw_left = $urandom_range(1, 12);
            end
            if (fg_left == 0) begin
                cur_fg  = !cur_fg;
                fg_left = $urandom_range(1, 15);
            end
            raw_left--;
            fg_left--;
            step(cur_raw, cur_fg, ($urandom_range(0, 299) != 0), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
